rr_burst_arbiter: RTL and testbench
===================================

// Module: rr_burst_arbiter
// PURPOSE
//   NUM_REQ-way round-robin arbiter for one shared resource (bus, port, engine).
//   A grant is held while its owner keeps requesting, up to MAX_BURST cycles.
//   After MAX_BURST, the grant is forced off if any other requester is waiting.
//   Drop-in scalable successor to the 2-requester IDLE/GNT0/GNT1 arbiter FSM; same
//   registered-grant, 1-cycle-latency timing.
// PARAMETERS
//   NUM_REQ    4   number of requesters, 2..16
//   MAX_BURST  8   max consecutive grant cycles before forced rotation, 1..255
//   (derived) ID_W = max(1,clog2(NUM_REQ)); CNT_W = clog2(MAX_BURST+1)
// PORTS
//   clock      in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   req        in   NUM_REQ  request vector, bit i = requester i; level, not pulse
//   gnt        out  NUM_REQ  registered grant, one-hot or all-zero
//   gnt_valid  out  1        |gnt
//   gnt_id     out  ID_W     index of granted requester; 0 when gnt_valid=0
//   preempt    out  1        1-cycle pulse, in the first cycle after a forced release
// BEHAVIOUR
// - Reset: applied at the clock edge. State=IDLE, gnt=0, gnt_valid=0, gnt_id=0,
//   preempt=0, ptr=0, burst count=0. Reset mid-grant drops gnt on the next edge
//   with no preempt pulse.
// - State register: IDLE, GRANT. All outputs come from flops; no comb path req->gnt.
// - Round-robin search: start at ptr, wrap NUM_REQ-1 -> 0, pick the first set req bit.
//   ptr = (granted id + 1) mod NUM_REQ, updated on every new grant.
// - IDLE:
//   - If req != 0: go to GRANT. gnt = onehot(pick), burst count = 1. The grant is
//     visible the cycle after req is sampled (1-cycle latency).
//   - Else: stay in IDLE.
// - GRANT, owner o:
//   - req[o]=0: go to IDLE. gnt clears next cycle. Count clears.
//   - req[o]=1, count<MAX_BURST: hold the grant, count+1.
//   - req[o]=1, count==MAX_BURST, (req & ~onehot(o)) != 0: go to IDLE, gnt clears,
//     preempt=1 for one cycle.
//   - req[o]=1, count==MAX_BURST, no other req: hold the grant. Count saturates
//     at MAX_BURST.
// - Every release passes through IDLE: one bubble cycle between grants, never
//   back-to-back grants to different owners.
// - Because ptr advances past o, a preempted owner is searched last next time.
// - A requester that drops req in the same cycle it would be picked is not granted.
//   The pick uses the sampled req only.
// - Starvation bound: a continuously requesting requester is granted within
//   (NUM_REQ-1)*(MAX_BURST+1)+1 cycles of entering IDLE.
// - Invariants: $onehot0(gnt); gnt_valid==|gnt; gnt_id matches gnt; preempt only
//   when gnt==0.
// - X on req during reset is ignored; after reset, req must be known.
// TESTING (NUM_REQ=4, MAX_BURST=4 unless noted)
// 1. Reset while req=4'b1111: gnt=0, preempt=0. Release reset -> gnt=0001 one cycle
//    later, ptr=1.
// 2. req=0001 held 10 cycles, others 0: gnt=0001 for all cycles after the first,
//    no preempt, no bubble.
// 3. req=1111 held: 0001 x4, preempt+bubble, 0010 x4, bubble, 0100 x4, bubble,
//    1000 x4, bubble, 0001. Check each preempt pulse.
// 4. After a grant to 3, ptr=0. req=0110: gnt=0010, then release req[1] -> bubble,
//    gnt=0100.
// 5. Drop req[o] in the cycle count hits MAX_BURST while req[2]=1: normal release,
//    preempt=0, next gnt=0100.
// 6. Random req for 10k cycles, NUM_REQ=3, MAX_BURST=1: invariants hold,
//    starvation bound met, reset injected mid-grant.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle for rr_burst_arbiter.
//   req        requester -> arbiter, one level-sensitive bit per requester
//   gnt        arbiter -> requester, registered one-hot or all-zero grant
//   gnt_valid  arbiter -> requester, high while any grant is held
//   gnt_id     arbiter -> requester, index of the granted requester (0 when idle)
//   preempt    arbiter -> requester, one-cycle pulse after a forced release
// master: the arbiter side. slave: the requester side.
interface rr_burst_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               preempt;

  modport master (input req, output gnt, gnt_valid, gnt_id, preempt);
  modport slave  (output req, input gnt, gnt_valid, gnt_id, preempt);
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded burst ownership for one shared resource.
// A grant is held while the owner keeps requesting; after MAX_BURST cycles it is
// forced off if anyone else is waiting. Every release passes through IDLE.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    rr_burst_arbiter_if.master (req in; gnt, gnt_valid, gnt_id, preempt out)
module rr_burst_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                clock,
  input  logic                reset,
  rr_burst_arbiter_if.master  bus
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_id;
  logic               owner_req;
  logic               others_req;

  // Round-robin pick: lowest set request at or above ptr, else wrap to lowest overall.
  always_comb begin
    hi_mask = ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
    masked  = bus.req & hi_mask;
    cand    = (|masked) ? masked : bus.req;
    pick_oh = cand & (~cand + NUM_REQ'(1));
    pick_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_id = ID_W'(i);
    end
  end

  assign owner_req  = |(bus.req & gnt_q);
  assign others_req = |(bus.req & ~gnt_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          valid_d = 1'b1;
          id_d    = pick_id;
          cnt_d   = CNT_W'(1);
          ptr_d   = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req || (cnt_q >= CNT_W'(MAX_BURST) && others_req)) begin
          // Release to IDLE; only a forced release flags preempt.
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          id_d      = '0;
          cnt_d     = '0;
          preempt_d = owner_req;
        end else if (cnt_q < CNT_W'(MAX_BURST)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        id_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = id_q;
  assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: dut_a (4 requesters, burst 4) for directed cases,
// dut_b (3 requesters, burst 1) for the long random run. Both share clock/reset.
module tb_rr_burst_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rr_burst_arbiter_if #(.NUM_REQ(4)) if_a ();
  rr_burst_arbiter_if #(.NUM_REQ(3)) if_b ();

  rr_burst_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut_a (.clock(clock), .reset(reset), .bus(if_a));
  rr_burst_arbiter #(.NUM_REQ(3), .MAX_BURST(1)) dut_b (.clock(clock), .reset(reset), .bus(if_b));

  int vectors = 0;
  int errors  = 0;
  bit use_b   = 1'b0;

  // Reference model: owner index (-1 = none), cycles held, next search start.
  int m_owner = -1;
  int m_held  = 0;
  int m_next  = 0;
  bit m_pre   = 1'b0;

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_next = 0; m_pre = 1'b0;
  endfunction

  function automatic void model_step(input int n, input int maxb, input logic [15:0] r);
    int c;
    logic [15:0] others;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < n; k++) begin
        c = (m_next + k) % n;
        if (r[c]) begin
          m_owner = c; m_held = 1; m_next = (c + 1) % n;
          break;
        end
      end
    end else begin
      others = r & ~(16'd1 << m_owner);
      if (!r[m_owner]) begin
        m_owner = -1; m_held = 0;
      end else if (m_held < maxb) begin
        m_held++;
      end else if (others != 16'd0) begin
        m_owner = -1; m_held = 0; m_pre = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] exp_a();
    logic [3:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, (m_owner >= 0), 2'((m_owner >= 0) ? m_owner : 0), m_pre};
  endfunction

  function automatic logic [7:0] obs_a();
    return {if_a.gnt, if_a.gnt_valid, if_a.gnt_id, if_a.preempt};
  endfunction

  function automatic logic [6:0] exp_b();
    logic [2:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {g, (m_owner >= 0), 2'((m_owner >= 0) ? m_owner : 0), m_pre};
  endfunction

  function automatic logic [6:0] obs_b();
    return {if_b.gnt, if_b.gnt_valid, if_b.gnt_id, if_b.preempt};
  endfunction

  // Apply one cycle of stimulus, advance the model, settle past the edge.
  task automatic drive(input logic [3:0] ra, input logic [2:0] rb, input logic rst);
    @(negedge clock);
    if_a.req = ra;
    if_b.req = rb;
    reset    = rst;
    @(posedge clock);
    if (rst) model_reset();
    else if (use_b) model_step(3, 1, 16'(rb));
    else model_step(4, 4, 16'(ra));
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 3'b000, 1'b1);
    drive(4'b1111, 3'b000, 1'b1);
    vectors++;
    if (if_a.gnt !== 4'b0000 || if_a.preempt !== 1'b0) begin
      errors++; $display("FAIL reset_hold: gnt=%b preempt=%b want gnt=0000 preempt=0", if_a.gnt, if_a.preempt);
    end
    drive(4'b1111, 3'b000, 1'b0);
    vectors++;
    if (if_a.gnt !== 4'b0001 || if_a.gnt_id !== 2'd0 || if_a.gnt_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant: gnt=%b id=%0d want 0001 id 0", if_a.gnt, if_a.gnt_id);
    end
    drive(4'b0000, 3'b000, 1'b0);
    vectors++;
    if (obs_a() !== exp_a()) begin
      errors++; $display("FAIL reset_release: got %b want %b", obs_a(), exp_a());
    end
    // ptr must now be 1, so requester 1 wins over 0.
    drive(4'b0011, 3'b000, 1'b0);
    vectors++;
    if (if_a.gnt !== 4'b0010) begin
      errors++; $display("FAIL reset_ptr: gnt=%b want 0010", if_a.gnt);
    end
    drive(4'b0000, 3'b000, 1'b0);
  endtask

  task automatic test_single_owner();
    drive(4'b0000, 3'b000, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive(4'b0001, 3'b000, 1'b0);
      vectors++;
      if (if_a.gnt !== 4'b0001 || if_a.preempt !== 1'b0 || obs_a() !== exp_a()) begin
        errors++; $display("FAIL single_owner cyc %0d: got %b want gnt 0001 model %b", c, obs_a(), exp_a());
      end
    end
    drive(4'b0000, 3'b000, 1'b0);
  endtask

  task automatic test_full_rotation();
    logic [3:0] want_g;
    logic       want_p;
    drive(4'b0000, 3'b000, 1'b1);
    for (int c = 0; c < 21; c++) begin
      drive(4'b1111, 3'b000, 1'b0);
      want_g = '0;
      want_p = 1'b0;
      if (c == 20) want_g = 4'b0001;
      else if ((c % 5) == 4) want_p = 1'b1;
      else want_g[c / 5] = 1'b1;
      vectors++;
      if (if_a.gnt !== want_g || if_a.preempt !== want_p || obs_a() !== exp_a()) begin
        errors++; $display("FAIL rotation cyc %0d: gnt=%b preempt=%b want gnt=%b preempt=%b", c, if_a.gnt, if_a.preempt, want_g, want_p);
      end
    end
    drive(4'b0000, 3'b000, 1'b0);
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] reqs [6];
    logic [3:0] wants[6];
    reqs  = '{4'b1000, 4'b0000, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
    wants = '{4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    drive(4'b0000, 3'b000, 1'b1);
    for (int c = 0; c < 6; c++) begin
      drive(reqs[c], 3'b000, 1'b0);
      vectors++;
      if (if_a.gnt !== wants[c] || if_a.preempt !== 1'b0 || obs_a() !== exp_a()) begin
        errors++; $display("FAIL ptr_wrap step %0d: gnt=%b preempt=%b want %b", c, if_a.gnt, if_a.preempt, wants[c]);
      end
    end
    drive(4'b0000, 3'b000, 1'b0);
  endtask

  task automatic test_drop_at_max();
    drive(4'b0000, 3'b000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(4'b0101, 3'b000, 1'b0);
      vectors++;
      if (if_a.gnt !== 4'b0001 || obs_a() !== exp_a()) begin
        errors++; $display("FAIL drop_max_hold cyc %0d: gnt=%b want 0001", c, if_a.gnt);
      end
    end
    drive(4'b0100, 3'b000, 1'b0);
    vectors++;
    if (if_a.gnt !== 4'b0000 || if_a.preempt !== 1'b0) begin
      errors++; $display("FAIL drop_max_release: gnt=%b preempt=%b want 0000 0", if_a.gnt, if_a.preempt);
    end
    drive(4'b0100, 3'b000, 1'b0);
    vectors++;
    if (if_a.gnt !== 4'b0100 || obs_a() !== exp_a()) begin
      errors++; $display("FAIL drop_max_next: gnt=%b want 0100", if_a.gnt);
    end
    drive(4'b0000, 3'b000, 1'b0);
  endtask

  task automatic test_random();
    localparam int LIMIT = (3 - 1) * (1 + 1) + 1 + (1 + 1);
    logic [2:0] rb;
    int  wait_cnt[3];
    bit  want_reset;
    rb = '0;
    want_reset = 1'b0;
    wait_cnt = '{0, 0, 0};
    use_b = 1'b1;
    drive(4'b0000, 3'b000, 1'b1);
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) want_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!rb[i]) rb[i] = ($urandom_range(0, 2) == 0);
        else if (if_b.gnt[i]) rb[i] = ($urandom_range(0, 1) == 0);
        else rb[i] = ($urandom_range(0, 7) != 0);
      end
      if (want_reset && if_b.gnt_valid) begin
        want_reset = 1'b0;
        drive(4'b0000, rb, 1'b1);
        vectors++;
        if (if_b.gnt !== 3'b000 || if_b.preempt !== 1'b0 || if_b.gnt_valid !== 1'b0) begin
          errors++; $display("FAIL rand_reset: gnt=%b preempt=%b want 000 0", if_b.gnt, if_b.preempt);
        end
        wait_cnt = '{0, 0, 0};
        continue;
      end
      drive(4'b0000, rb, 1'b0);
      vectors++;
      if (obs_b() !== exp_b()) begin
        errors++; $display("FAIL rand_model cyc %0d: got %b want %b req %b", c, obs_b(), exp_b(), rb);
      end
      vectors++;
      if (!$onehot0(if_b.gnt) || if_b.gnt_valid !== (|if_b.gnt) ||
          if_b.gnt !== (if_b.gnt_valid ? 3'(3'b001 << if_b.gnt_id) : 3'b000) ||
          (if_b.preempt && if_b.gnt !== 3'b000)) begin
        errors++; $display("FAIL rand_invariant cyc %0d: gnt=%b valid=%b id=%0d preempt=%b", c, if_b.gnt, if_b.gnt_valid, if_b.gnt_id, if_b.preempt);
      end
      for (int i = 0; i < 3; i++) begin
        if (if_b.gnt[i] || !rb[i]) begin
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
          vectors++;
          if (wait_cnt[i] > LIMIT) begin
            errors++; $display("FAIL rand_starve cyc %0d: req %0d waited %0d want <= %0d", c, i, wait_cnt[i], LIMIT);
            wait_cnt[i] = 0;
          end
        end
      end
    end
    vectors++;
    if (want_reset) begin
      errors++; $display("FAIL rand_reset_inject: injected %b want %b", 1'b0, 1'b1);
    end
    drive(4'b0000, 3'b000, 1'b0);
    use_b = 1'b0;
  endtask

  initial begin
    if_a.req = '0;
    if_b.req = '0;
    test_reset();
    test_single_owner();
    test_full_rotation();
    test_ptr_wrap();
    test_drop_at_max();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
